// File: rtl/fc_seq_ctrl_if.sv
// Handshake bundle for fc_seq_ctrl: input activation stream and output result stream.
// Ports: in_valid/in_ready/in_data (activations in), out_valid/out_ready/out_data/out_idx/out_last.
interface fc_seq_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int ZW    = 23,
    parameter int IW    = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [ZW-1:0]    out_data;
    logic [IW-1:0]    out_idx;
    logic             out_last;

    // master: the sequencer itself; slave: the upstream/downstream environment
    modport master (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );

    modport slave (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );
endinterface

// File: rtl/fc_seq_ctrl.sv
// Fully-connected layer sequencer: loads IN activations onto x_bus, waits SETTLE_CYC cycles,
// captures N_OUT neuron results from z_bus and streams them out one per valid/ready handshake.
// Ports: clk, rst_n (sync, active-low), bus (fc_seq_ctrl_if.master), x_bus, z_bus, busy,
// class_valid/class_idx (argmax result, only live when FC_SEQ_ARGMAX_EN is defined).
module fc_seq_ctrl #(
    parameter int WIDTH      = 8,
    parameter int IN         = 128,
    parameter int N_OUT      = 10,
    parameter int ZW         = 23,
    parameter int SETTLE_CYC = 2,
    localparam int IW        = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    fc_seq_ctrl_if.master       bus,
    output logic [IN*WIDTH-1:0] x_bus,
    input  logic [N_OUT*ZW-1:0] z_bus,
    output logic                busy,
    output logic                class_valid,
    output logic [IW-1:0]       class_idx
);
    localparam int CW = (IN > 1) ? $clog2(IN) : 1;
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(IN - 1);
    localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_OUT - 1);

    typedef enum logic [1:0] {
        LOAD,
        SETTLE,
        DRAIN
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [SW-1:0] scnt;
    logic [ZW-1:0] z_reg [N_OUT];
    logic [IW-1:0] nxt_idx;
    logic          in_hs;
    logic          out_hs;

    // in_ready/out_valid are registered and only high in LOAD/DRAIN,
    // so the raw handshakes already imply the state.
    assign in_hs   = bus.in_valid & bus.in_ready;
    assign out_hs  = bus.out_valid & bus.out_ready;
    assign nxt_idx = bus.out_idx + 1'b1;

`ifdef FC_SEQ_ARGMAX_EN
    logic [ZW-1:0] max_val;
    logic [IW-1:0] max_idx;
    logic          take;

    // First result seeds the max; later ones replace it only if strictly
    // greater, so ties keep the lower index.
    assign take = (bus.out_idx == '0) || (bus.out_data > max_val);
`else
    assign class_valid = 1'b0;
    assign class_idx   = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= LOAD;
            cnt           <= '0;
            scnt          <= '0;
            x_bus         <= '0;
            for (int j = 0; j < N_OUT; j++) z_reg[j] <= '0;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_idx   <= '0;
            bus.out_last  <= 1'b0;
            busy          <= 1'b0;
`ifdef FC_SEQ_ARGMAX_EN
            max_val       <= '0;
            max_idx       <= '0;
            class_valid   <= 1'b0;
            class_idx     <= '0;
`endif
        end else begin
`ifdef FC_SEQ_ARGMAX_EN
            class_valid <= 1'b0;
`endif
            unique case (state)
                LOAD: begin
                    bus.in_ready <= 1'b1;
                    if (in_hs) begin
                        x_bus[int'(cnt)*WIDTH +: WIDTH] <= bus.in_data;
                        if (cnt == CNT_LAST) begin
                            cnt          <= '0;
                            scnt         <= '0;
                            state        <= SETTLE;
                            bus.in_ready <= 1'b0;
                            busy         <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    if (scnt == SET_LAST) begin
                        scnt  <= '0;
                        state <= DRAIN;
                        for (int j = 0; j < N_OUT; j++) begin
                            z_reg[j] <= z_bus[j*ZW +: ZW];
                        end
                        // result 0 is presented straight from z_bus on capture
                        bus.out_valid <= 1'b1;
                        bus.out_data  <= z_bus[0 +: ZW];
                        bus.out_idx   <= '0;
                        bus.out_last  <= (IDX_LAST == '0);
                    end else begin
                        scnt <= scnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (out_hs) begin
`ifdef FC_SEQ_ARGMAX_EN
                        if (take) begin
                            max_val <= bus.out_data;
                            max_idx <= bus.out_idx;
                        end
`endif
                        if (bus.out_idx == IDX_LAST) begin
                            state         <= LOAD;
                            bus.out_valid <= 1'b0;
                            bus.out_last  <= 1'b0;
                            bus.out_idx   <= '0;
                            bus.in_ready  <= 1'b1;
                            busy          <= 1'b0;
`ifdef FC_SEQ_ARGMAX_EN
                            class_valid   <= 1'b1;
                            class_idx     <= take ? bus.out_idx : max_idx;
`endif
                        end else begin
                            bus.out_idx  <= nxt_idx;
                            bus.out_data <= z_reg[nxt_idx];
                            bus.out_last <= (nxt_idx == IDX_LAST);
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_fc_seq_ctrl.sv
// Self-checking bench for fc_seq_ctrl with a stand-in neuron layer driving z_bus.
// Honors FC_SEQ_ARGMAX_EN the same way the design does.
module tb_fc_seq_ctrl;
    localparam int WIDTH      = 8;
    localparam int IN         = 128;
    localparam int N_OUT      = 10;
    localparam int ZW         = 23;
    localparam int SETTLE_CYC = 2;
    localparam int IW         = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [IN*WIDTH-1:0] x_bus;
    logic [N_OUT*ZW-1:0] z_bus;
    logic                busy;
    logic                class_valid;
    logic [IW-1:0]       class_idx;

    fc_seq_ctrl_if #(.WIDTH(WIDTH), .ZW(ZW), .IW(IW)) bus ();

    fc_seq_ctrl #(
        .WIDTH(WIDTH), .IN(IN), .N_OUT(N_OUT), .ZW(ZW), .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .x_bus(x_bus),
        .z_bus(z_bus),
        .busy(busy),
        .class_valid(class_valid),
        .class_idx(class_idx)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int hs_cyc = 0;
    int cls_seen = 0;

    logic [WIDTH-1:0] sent [IN];
    logic [ZW-1:0]    exp_z [N_OUT];
    logic             force_z = 1'b0;
    logic [ZW-1:0]    force_tab [N_OUT];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (class_valid === 1'b1) cls_seen <= cls_seen + 1;

    // stand-in layer: z_j = sum_k x_k * ((k+j) mod 5)
    function automatic logic [ZW-1:0] layer_z(input logic [IN*WIDTH-1:0] x, input int j);
        int acc = 0;
        for (int k = 0; k < IN; k++) begin
            acc += int'({24'h0, x[k*WIDTH +: WIDTH]}) * ((k + j) % 5);
        end
        return ZW'(acc);
    endfunction

    always_comb begin
        z_bus = '0;
        for (int j = 0; j < N_OUT; j++) begin
            z_bus[j*ZW +: ZW] = force_z ? force_tab[j] : layer_z(x_bus, j);
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [IN*WIDTH-1:0] pack_sent();
        logic [IN*WIDTH-1:0] p = '0;
        for (int k = 0; k < IN; k++) p[k*WIDTH +: WIDTH] = sent[k];
        return p;
    endfunction

    function automatic int exp_arg();
        int best = 0;
        for (int j = 1; j < N_OUT; j++) if (exp_z[j] > exp_z[best]) best = j;
        return best;
    endfunction

    function automatic int x_bad();
        int bad = 0;
        for (int k = 0; k < IN; k++) if (x_bus[k*WIDTH +: WIDTH] !== sent[k]) bad++;
        return bad;
    endfunction

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", int'(bus.in_ready), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
        chk("rst_out_idx", int'(bus.out_idx), 0);
        chk("rst_out_last", int'(bus.out_last), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cls_v", int'(class_valid), 0);
        chk("rst_cls_idx", int'(class_idx), 0);
        chk("rst_x_bus", int'(|x_bus), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", int'(bus.in_ready), 1);
        chk("rel_busy", int'(busy), 0);
    endtask

    task automatic send_frame(input bit gaps, input bit rnd, input int stop_at);
        int k = 0;
        int budget = 0;
        while (k < stop_at && budget < 2000) begin
            @(negedge clk);
            budget++;
            bus.in_data  = rnd ? WIDTH'($urandom_range(0, 255)) : WIDTH'(k % 256);
            bus.in_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (bus.in_valid && bus.in_ready) begin
                if (k == IN - 1) begin
                    chk("busy_pre_last", int'(busy), 0);
                    hs_cyc = cyc;
                end
                sent[k] = bus.in_data;
                k++;
            end
        end
        if (k < stop_at) chk("tmo_in", k, stop_at);
    endtask

    task automatic drain(input bit bp, input bit hold);
        int idx = 0;
        int step = 0;
        int budget = 0;
        int vcyc = -1;
        int leak = 0;
        logic pv = 1'b0;
        logic pr = 1'b0;
        logic [ZW-1:0] pd = '0;
        logic [IW-1:0] pi = '0;
        logic [3:0] pat = 4'b1001;
        for (int j = 0; j < N_OUT; j++) begin
            exp_z[j] = force_z ? force_tab[j] : layer_z(pack_sent(), j);
        end
        while (idx < N_OUT && budget < 200) begin
            @(negedge clk);
            budget++;
            bus.in_valid = hold;
            if (bus.in_valid && bus.in_ready) leak++;
            if (bus.out_valid) begin
                if (vcyc < 0) begin
                    vcyc = cyc;
                    chk("latency", vcyc - hs_cyc, SETTLE_CYC + 1);
                    chk("x_elem5", int'(x_bus[5*WIDTH +: WIDTH]), int'(sent[5]));
                    chk("x_bus_bad", x_bad(), 0);
                end
                if (pv && !pr) begin
                    chk("stall_data", int'(bus.out_data), int'(pd));
                    chk("stall_idx", int'(bus.out_idx), int'(pi));
                end
                chk("out_idx", int'(bus.out_idx), idx);
                chk("out_data", int'(bus.out_data), int'(exp_z[idx]));
                chk("out_last", int'(bus.out_last), int'(idx == N_OUT - 1));
                bus.out_ready = bp ? pat[step % 4] : 1'b1;
                step++;
                if (bus.out_ready) idx++;
            end else begin
                bus.out_ready = ($urandom_range(0, 1) == 1);
            end
            pv = bus.out_valid;
            pr = bus.out_ready;
            pd = bus.out_data;
            pi = bus.out_idx;
        end
        if (idx < N_OUT) chk("tmo_out", idx, N_OUT);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("post_out_valid", int'(bus.out_valid), 0);
        chk("post_in_ready", int'(bus.in_ready), 1);
        chk("post_busy", int'(busy), 0);
        chk("in_leak", leak, 0);
        chk("x_keep_bad", x_bad(), 0);
`ifdef FC_SEQ_ARGMAX_EN
        chk("cls_valid", int'(class_valid), 1);
        chk("cls_idx", int'(class_idx), exp_arg());
        @(negedge clk);
        chk("cls_pulse_end", int'(class_valid), 0);
`endif
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        for (int j = 0; j < N_OUT; j++) force_tab[j] = '0;
        force_tab[0] = ZW'(5);
        force_tab[1] = ZW'(9);
        force_tab[2] = ZW'(3);
        force_tab[3] = ZW'(9);

        do_reset(3);
        send_frame(1'b0, 1'b0, IN);
        drain(1'b0, 1'b0);
        send_frame(1'b0, 1'b0, IN);
        drain(1'b1, 1'b1);
        send_frame(1'b1, 1'b0, IN);
        drain(1'b1, 1'b0);
        send_frame(1'b0, 1'b1, 60);
        do_reset(2);
        send_frame(1'b1, 1'b1, IN);
        drain(1'b1, 1'b1);
        send_frame(1'b0, 1'b1, IN);
        drain(1'b0, 1'b0);
        force_z = 1'b1;
        send_frame(1'b0, 1'b1, IN);
        drain(1'b1, 1'b0);
        force_z = 1'b0;
`ifndef FC_SEQ_ARGMAX_EN
        chk("cls_off_pulses", cls_seen, 0);
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
